// File: rtl/udt_conn_ctrl.sv
// -----------------------------------------------------------------------------
// udt_conn_ctrl
//   Connection-sequencing controller that sits between the configuration
//   register block and the Socket Manager. It accepts connect/close commands,
//   checks them against the current connection state, and drives the
//   Req_Connect / Req_Close level handshakes with a timeout. Connect attempts
//   are retried after a timeout; close attempts are not. Every state change or
//   err_code write is reported as a status word.
//
// Parameters
//   TIMEOUT_CYCLES : core_clk cycles per attempt before it times out (>= 2)
//   MAX_RETRY      : extra connect attempts after the first timeout (0..15)
//
// Ports
//   core_clk, core_rst_n        : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op  : command handshake (01 connect, 10 close,
//                                 anything else is illegal)
//   Req_Connect/Res_Connect     : open request level / completion pulse
//   Req_Close/Res_Close         : close request level / completion or peer
//                                 close pulse
//   udt_state/state_valid/state_ready : status word handshake
//                                 ([2:0] state, [6:4] err_code, [11:8] retry)
//
// Optional build macro
//   UDT_CONN_STATS_EN : adds saturating event counters connect_ok_cnt,
//                       timeout_cnt and peer_close_cnt (16 bits each).
// -----------------------------------------------------------------------------
module udt_conn_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic        core_clk,
  input  logic        core_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  output logic        Req_Connect,
  input  logic        Res_Connect,
  output logic        Req_Close,
  input  logic        Res_Close,
  output logic [31:0] udt_state,
  output logic        state_valid,
  input  logic        state_ready
`ifdef UDT_CONN_STATS_EN
  ,
  output logic [15:0] connect_ok_cnt,
  output logic [15:0] timeout_cnt,
  output logic [15:0] peer_close_cnt
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_CLOSED     = 3'd0,
    ST_CONNECTING = 3'd1,
    ST_CONNECTED  = 3'd2,
    ST_CLOSING    = 3'd3,
    ST_FAILED     = 3'd4
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_DUP     = 3'd1;
  localparam logic [2:0] ERR_NOTOPEN = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_BADOP   = 3'd4;

  localparam logic [TW-1:0] TIMER_TC  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  state_t          state_q, state_d;
  logic [2:0]      err_q, err_d;
  logic [3:0]      retry_q, retry_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            dup_q, dup_d;      // CLOSING was entered because of DUP_CONNECT
  logic            gap_q, gap_d;      // one-cycle Req_Connect drop between retries
  logic            active_q;          // holds cmd_ready low while in reset
  logic [31:0]     udt_state_q, udt_state_d;
  logic            state_valid_q, state_valid_d;

  logic            cmd_fire;
  logic            timer_tc;
  logic            upd;
  logic            ev_ok, ev_timeout, ev_peer;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign timer_tc = (timer_q == TIMER_TC);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q       <= ST_CLOSED;
      err_q         <= ERR_NONE;
      retry_q       <= 4'd0;
      timer_q       <= '0;
      dup_q         <= 1'b0;
      gap_q         <= 1'b0;
      active_q      <= 1'b0;
      udt_state_q   <= 32'd0;
      state_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_q         <= err_d;
      retry_q       <= retry_d;
      timer_q       <= timer_d;
      dup_q         <= dup_d;
      gap_q         <= gap_d;
      active_q      <= 1'b1;
      udt_state_q   <= udt_state_d;
      state_valid_q <= state_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    retry_d    = retry_q;
    timer_d    = timer_q;
    dup_d      = dup_q;
    gap_d      = 1'b0;
    upd        = 1'b0;
    ev_ok      = 1'b0;
    ev_timeout = 1'b0;
    ev_peer    = 1'b0;

    // The timer only runs while a request is outstanding; the retry gap
    // cycle counts as part of the new attempt.
    if (state_q == ST_CONNECTING || state_q == ST_CLOSING) begin
      timer_d = timer_q + 1'b1;
    end

    case (state_q)
      ST_CLOSED, ST_FAILED: begin
        if (cmd_fire) begin
          upd = 1'b1;
          case (cmd_op)
            2'b01: begin
              state_d = ST_CONNECTING;
              err_d   = ERR_NONE;
              retry_d = 4'd0;
              timer_d = '0;
              dup_d   = 1'b0;
            end
            2'b10:   err_d = ERR_NOTOPEN;
            default: err_d = ERR_BADOP;
          endcase
        end
      end

      ST_CONNECTED: begin
        // Peer close is decoded ahead of commands (cmd_ready is low then).
        if (Res_Close) begin
          state_d = ST_CLOSED;
          err_d   = ERR_NONE;
          upd     = 1'b1;
          ev_peer = 1'b1;
        end else if (cmd_fire) begin
          upd = 1'b1;
          case (cmd_op)
            2'b01: begin
              state_d = ST_CLOSING;
              err_d   = ERR_DUP;
              dup_d   = 1'b1;
              timer_d = '0;
            end
            2'b10: begin
              state_d = ST_CLOSING;
              dup_d   = 1'b0;
              timer_d = '0;
            end
            default: err_d = ERR_BADOP;
          endcase
        end
      end

      ST_CONNECTING: begin
        // A response in the terminal-count cycle still wins.
        if (Res_Connect) begin
          state_d = ST_CONNECTED;
          timer_d = '0;
          upd     = 1'b1;
          ev_ok   = 1'b1;
        end else if (timer_tc) begin
          ev_timeout = 1'b1;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 4'd1;
            gap_d   = 1'b1;
            timer_d = '0;
          end else begin
            state_d = ST_FAILED;
            err_d   = ERR_TIMEOUT;
            timer_d = '0;
            upd     = 1'b1;
          end
        end
      end

      ST_CLOSING: begin
        if (Res_Close) begin
          state_d = dup_q ? ST_FAILED : ST_CLOSED;
          dup_d   = 1'b0;
          timer_d = '0;
          upd     = 1'b1;
        end else if (timer_tc) begin
          state_d    = ST_FAILED;
          err_d      = ERR_TIMEOUT;
          dup_d      = 1'b0;
          timer_d    = '0;
          upd        = 1'b1;
          ev_timeout = 1'b1;
        end
      end

      default: begin
        state_d = ST_CLOSED;
        timer_d = '0;
      end
    endcase

    // Status word: latest update wins; valid clears only on an idle handshake.
    udt_state_d   = udt_state_q;
    state_valid_d = state_valid_q;
    if (upd) begin
      udt_state_d   = {20'd0, retry_d, 1'b0, err_d, 1'b0, state_d};
      state_valid_d = 1'b1;
    end else if (state_valid_q && state_ready) begin
      state_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from flops so reset drops the requests immediately)
  // ---------------------------------------------------------------------------
  always_comb begin
    Req_Connect = (state_q == ST_CONNECTING) && !gap_q;
    Req_Close   = (state_q == ST_CLOSING);
    cmd_ready   = 1'b0;
    if (active_q) begin
      cmd_ready = (state_q == ST_CLOSED) || (state_q == ST_FAILED) ||
                  ((state_q == ST_CONNECTED) && !Res_Close);
    end
    udt_state   = udt_state_q;
    state_valid = state_valid_q;
  end

`ifdef UDT_CONN_STATS_EN
  logic [15:0] ok_cnt_q, ok_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [15:0] pc_cnt_q, pc_cnt_d;

  always_comb begin
    ok_cnt_d = ok_cnt_q;
    to_cnt_d = to_cnt_q;
    pc_cnt_d = pc_cnt_q;
    if (ev_ok      && ok_cnt_q != 16'hFFFF) ok_cnt_d = ok_cnt_q + 16'd1;
    if (ev_timeout && to_cnt_q != 16'hFFFF) to_cnt_d = to_cnt_q + 16'd1;
    if (ev_peer    && pc_cnt_q != 16'hFFFF) pc_cnt_d = pc_cnt_q + 16'd1;
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      ok_cnt_q <= 16'd0;
      to_cnt_q <= 16'd0;
      pc_cnt_q <= 16'd0;
    end else begin
      ok_cnt_q <= ok_cnt_d;
      to_cnt_q <= to_cnt_d;
      pc_cnt_q <= pc_cnt_d;
    end
  end

  assign connect_ok_cnt = ok_cnt_q;
  assign timeout_cnt    = to_cnt_q;
  assign peer_close_cnt = pc_cnt_q;
`endif

endmodule
